serial_regfile_slave: RTL and testbench

- Parametrised serial slave that fronts a configuration register file for the SerDes macro: a host shifts in command, address and data on a single `din` pin and reads data back on `dout`.
- Read/write direction is carried in-band as a command bit, which replaces the separate write-enable pin used on the fixed-width SIPO/PISO slave.
- Adds auto-increment burst access, out-of-range detection and a frame-abort rule.
- All register contents are exported as a flat parallel bus to the analog/config logic.

---
 rtl/serial_regfile_slave_pkg.sv | 33 +++
 rtl/serial_regfile_slave_if.sv | 35 +++
 rtl/serial_regfile_core.sv | 54 +++++
 rtl/serial_regfile_slave.sv | 190 +++++++++++++++++++
 tb/tb_serial_regfile_slave.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_regfile_slave_pkg.sv
// Shared definitions for the serial register-file slave: FSM state encoding,
// command bit values and sizing helpers.
package serial_regfile_slave_pkg;

    // Frame FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_TURN = 3'd3,
        ST_DATA = 3'd4
    } state_e;

    // In-band command bit values
    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

    // Bit-counter width: must index both the address field and a data word
    // including an optional parity bit.
    function automatic int unsigned cnt_width(int unsigned addr_width,
                                              int unsigned reg_width);
        int unsigned max_len;
        max_len = (addr_width > reg_width + 1) ? addr_width : reg_width + 1;
        return $clog2(max_len);
    endfunction

    // True when an address maps onto an implemented register
    function automatic logic addr_in_range(int unsigned addr,
                                           int unsigned num_regs);
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/serial_regfile_slave_if.sv
// Serial host/slave pin bundle.
//   strobe  : frame start/abort (host -> slave)
//   din     : serial data in, LSB first (host -> slave)
//   dout    : registered serial read data (slave -> host)
//   rw_flag : dout carries valid read data (slave -> host)
//   busy    : frame in progress (slave -> host)
//   err     : sticky error, cleared at frame start (slave -> host)
interface serial_regfile_slave_if;

    logic strobe;
    logic din;
    logic dout;
    logic rw_flag;
    logic busy;
    logic err;

    modport master (
        output strobe,
        output din,
        input  dout,
        input  rw_flag,
        input  busy,
        input  err
    );

    modport slave (
        input  strobe,
        input  din,
        output dout,
        output rw_flag,
        output busy,
        output err
    );

endinterface

// File: rtl/serial_regfile_core.sv
// Register storage: NUM_REGS x REG_WIDTH with one write port, one read mux
// (unimplemented addresses read as zero) and flat parallel export.
//   clk, rst_n  : clock, synchronous active-low reset (loads RESET_VAL)
//   wr_en_i     : write strobe for wr_addr_i / wr_data_i
//   rd_addr_i   : combinational read address -> rd_data_o
//   regs_o      : reg k at bits [k*REG_WIDTH +: REG_WIDTH]
module serial_regfile_core #(
    parameter int unsigned          ADDR_WIDTH = 5,
    parameter int unsigned          REG_WIDTH  = 8,
    parameter int unsigned          NUM_REGS   = 17,
    parameter logic [REG_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en_i,
    input  logic [ADDR_WIDTH-1:0]           wr_addr_i,
    input  logic [REG_WIDTH-1:0]            wr_data_i,
    input  logic [ADDR_WIDTH-1:0]           rd_addr_i,
    output logic [REG_WIDTH-1:0]            rd_data_o,
    output logic [NUM_REGS*REG_WIDTH-1:0]   regs_o
);

    logic [REG_WIDTH-1:0] regs_q [NUM_REGS];

    // Storage; addresses with no matching register are silently ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else if (wr_en_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_addr_i == ADDR_WIDTH'(k)) begin
                    regs_q[k] <= wr_data_i;
                end
            end
        end
    end

    // Read mux; falls through to zero when out of range
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr_i == ADDR_WIDTH'(k)) begin
                rd_data_o = regs_q[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
        assign regs_o[k*REG_WIDTH +: REG_WIDTH] = regs_q[k];
    end

endmodule

// File: rtl/serial_regfile_slave.sv
// Serial slave fronting a configuration register file. Frame: strobe, command
// bit (1=write, 0=read), ADDR_WIDTH address bits, then auto-incrementing data
// words (LSB first) until the next strobe or reset. Reads insert one TURN cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   bus_if     : serial pins (strobe, din, dout, rw_flag, busy, err), slave side
//   regs_o     : flat register file contents
// Optional: define SERIAL_REGFILE_PARITY_EN to append one even-parity bit to
// every data word in both directions.
module serial_regfile_slave
    import serial_regfile_slave_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 5,
    parameter int unsigned          REG_WIDTH  = 8,
    parameter int unsigned          NUM_REGS   = 17,
    parameter logic [REG_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    serial_regfile_slave_if.slave         bus_if,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_o
);

`ifdef SERIAL_REGFILE_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned     WORD_LEN  = REG_WIDTH + PAR_BITS;
    localparam int unsigned     CNT_W     = cnt_width(ADDR_WIDTH, REG_WIDTH);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_LEN - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    cmd_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [REG_WIDTH-1:0]    wsh_q;
    logic [WORD_LEN-1:0]     rsh_q;
    logic                    dout_q;
    logic                    rw_flag_q;
    logic                    busy_q;
    logic                    err_q;

    logic [ADDR_WIDTH-1:0]   rd_addr_c;
    logic [REG_WIDTH-1:0]    rd_data_c;
    logic [WORD_LEN-1:0]     rd_word_c;
    logic                    rd_ok_c;
    logic [REG_WIDTH-1:0]    wsh_c;
    logic                    wr_ok_c;
    logic                    wr_par_ok_c;
    logic                    word_end_c;
    logic                    wr_en_c;

    assign word_end_c = (state_q == ST_DATA) && (cnt_q == WORD_LAST);

    // TURN fetches the frame address; a finishing burst word fetches the next one
    assign rd_addr_c = (state_q == ST_TURN) ? addr_q : addr_q + ADDR_WIDTH'(1);
    assign rd_ok_c   = addr_in_range(32'(rd_addr_c), NUM_REGS);
    assign wr_ok_c   = addr_in_range(32'(addr_q), NUM_REGS);

    // Write word with the current din placed at the bit being sampled; at a
    // parity edge no data bit matches, so the word is the completed shift reg.
    always_comb begin
        wsh_c = wsh_q;
        for (int k = 0; k < REG_WIDTH; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                wsh_c[k] = bus_if.din;
            end
        end
    end

`ifdef SERIAL_REGFILE_PARITY_EN
    assign rd_word_c   = {^rd_data_c, rd_data_c};
    assign wr_par_ok_c = ((^wsh_q) == bus_if.din);
`else
    assign rd_word_c   = rd_data_c;
    assign wr_par_ok_c = 1'b1;
`endif

    // Strobe and reset take priority over a commit on the same edge
    assign wr_en_c = rst_n && !bus_if.strobe && word_end_c && (cmd_q == CMD_WR)
                     && wr_ok_c && wr_par_ok_c;

    serial_regfile_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_WIDTH  (REG_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RESET_VAL  (RESET_VAL)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en_c),
        .wr_addr_i  (addr_q),
        .wr_data_i  (wsh_c),
        .rd_addr_i  (rd_addr_c),
        .rd_data_o  (rd_data_c),
        .regs_o     (regs_o)
    );

    // Frame FSM, shifters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_q     <= CMD_RD;
            addr_q    <= '0;
            wsh_q     <= '0;
            rsh_q     <= '0;
            dout_q    <= 1'b0;
            rw_flag_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (bus_if.strobe) begin
            state_q   <= ST_CMD;
            cnt_q     <= '0;
            dout_q    <= 1'b0;
            rw_flag_q <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_CMD: begin
                    cmd_q   <= bus_if.din;
                    cnt_q   <= '0;
                    state_q <= ST_ADDR;
                end
                ST_ADDR: begin
                    addr_q <= {bus_if.din, addr_q[ADDR_WIDTH-1:1]};
                    if (cnt_q == ADDR_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (cmd_q == CMD_WR) ? ST_DATA : ST_TURN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_TURN: begin
                    dout_q    <= rd_word_c[0];
                    rsh_q     <= rd_word_c >> 1;
                    rw_flag_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_DATA;
                    if (!rd_ok_c) begin
                        err_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cmd_q == CMD_RD) begin
                        if (word_end_c) begin
                            // Back-to-back burst: next word with no gap
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                            dout_q <= rd_word_c[0];
                            rsh_q  <= rd_word_c >> 1;
                            cnt_q  <= '0;
                            if (!rd_ok_c) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            dout_q <= rsh_q[0];
                            rsh_q  <= rsh_q >> 1;
                            cnt_q  <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        wsh_q <= wsh_c;
                        if (word_end_c) begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                            cnt_q  <= '0;
                            if (!(wr_ok_c && wr_par_ok_c)) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.dout    = dout_q;
    assign bus_if.rw_flag = rw_flag_q;
    assign bus_if.busy    = busy_q;
    assign bus_if.err     = err_q;

endmodule

// File: tb/tb_serial_regfile_slave.sv
// Directed self-checking bench for serial_regfile_slave (default parameters).
module tb_serial_regfile_slave;

    localparam int AW = 5;
    localparam int RW = 8;
    localparam int NR = 17;
`ifdef SERIAL_REGFILE_PARITY_EN
    localparam int WL = RW + 1;
`else
    localparam int WL = RW;
`endif

    logic              clk;
    logic              rst_n;
    logic [NR*RW-1:0]  regs_o;
    logic [RW-1:0]     mdl [NR];

    int checks;
    int failures;

    serial_regfile_slave_if bus ();

    serial_regfile_slave #(
        .ADDR_WIDTH (AW),
        .REG_WIDTH  (RW),
        .NUM_REGS   (NR),
        .RESET_VAL  ('0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus),
        .regs_o (regs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] reg_at(input int k);
        return regs_o[k*RW +: RW];
    endfunction

    task automatic send_cmd_addr(input logic cmd, input logic [AW-1:0] addr);
        bus.din = cmd;
        tick();
        for (int i = 0; i < AW; i++) begin
            bus.din = addr[i];
            tick();
        end
        bus.din = 1'b0;
    endtask

    task automatic start_frame(input logic cmd, input logic [AW-1:0] addr);
        bus.strobe = 1'b1;
        bus.din    = 1'b0;
        tick();
        bus.strobe = 1'b0;
        send_cmd_addr(cmd, addr);
    endtask

    // One write word; bad_par flips the parity bit when parity is built in
    task automatic send_word(input logic [RW-1:0] val, input logic bad_par);
        for (int i = 0; i < RW; i++) begin
            bus.din = val[i];
            tick();
        end
`ifdef SERIAL_REGFILE_PARITY_EN
        bus.din = (^val) ^ bad_par;
        tick();
`else
        if (bad_par) bus.din = 1'b0;
`endif
        bus.din = 1'b0;
    endtask

    task automatic strobe_only();
        bus.strobe = 1'b1;
        tick();
        bus.strobe = 1'b0;
    endtask

    // Checks nbits of a read word; with stop, strobes on the final bit's edge
    task automatic read_bits(input string tag, input logic [RW-1:0] val,
                             input int nbits, input bit stop);
        logic [RW:0] w;
        w = {^val, val};
        for (int k = 0; k < nbits; k++) begin
            chk({tag, "_dout"}, 32'(bus.dout), 32'(w[k]));
            chk({tag, "_rwflag"}, 32'(bus.rw_flag), 32'd1);
            if (stop && k == nbits - 1) bus.strobe = 1'b1;
            tick();
            bus.strobe = 1'b0;
        end
        if (stop) chk({tag, "_rwdrop"}, 32'(bus.rw_flag), 32'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.strobe = 1'b0;
        bus.din    = 1'b0;
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        tick();
        tick();

        // Reset state
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_rwflag", 32'(bus.rw_flag), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_reg3", 32'(reg_at(3)), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single write addr 3 = 0x0E
        start_frame(1'b1, 5'd3);
        chk("wr3_busy", 32'(bus.busy), 32'd1);
        chk("wr3_pre", 32'(reg_at(3)), 32'd0);
        send_word(8'h0E, 1'b0);
        chk("wr3_reg", 32'(regs_o[31:24]), 32'h0E);
        chk("wr3_err", 32'(bus.err), 32'd0);
        mdl[3] = 8'h0E;

        // Single read addr 3: TURN cycle then 0x0E LSB first
        start_frame(1'b0, 5'd3);
        chk("rd3_turn_dout", 32'(bus.dout), 32'd0);
        chk("rd3_turn_rw", 32'(bus.rw_flag), 32'd0);
        tick();
        read_bits("rd3", 8'h0E, WL, 1'b1);

        // Burst write from 15: 0xAA, 0x55, then 0x3C to addr 17 is dropped
        start_frame(1'b1, 5'd15);
        send_word(8'hAA, 1'b0);
        chk("bw_reg15", 32'(reg_at(15)), 32'hAA);
        send_word(8'h55, 1'b0);
        chk("bw_reg16", 32'(reg_at(16)), 32'h55);
        chk("bw_err_ok", 32'(bus.err), 32'd0);
        send_word(8'h3C, 1'b0);
        chk("bw_err_oor", 32'(bus.err), 32'd1);
        chk("bw_reg0", 32'(reg_at(0)), 32'd0);
        mdl[15] = 8'hAA;
        mdl[16] = 8'h55;
        strobe_only();
        chk("bw_err_clr", 32'(bus.err), 32'd0);
        chk("bw_busy", 32'(bus.busy), 32'd1);

        // Load all registers with a burst write
        for (int k = 0; k < NR; k++) mdl[k] = 8'(k * 37 + 5);
        start_frame(1'b1, 5'd0);
        for (int k = 0; k < NR; k++) send_word(mdl[k], 1'b0);
        strobe_only();
        for (int k = 0; k < NR; k++) chk("load_reg", 32'(reg_at(k)), 32'(mdl[k]));
        chk("load_err", 32'(bus.err), 32'd0);

        // Burst read of all 17 words, no gap between words
        start_frame(1'b0, 5'd0);
        tick();
        for (int k = 0; k < NR; k++) read_bits("brd", mdl[k], WL, k == NR - 1);
        chk("brd_err", 32'(bus.err), 32'd0);

        // Out-of-range read of addr 20 returns zero and flags err
        start_frame(1'b0, 5'd20);
        chk("oor_err_pre", 32'(bus.err), 32'd0);
        tick();
        chk("oor_err", 32'(bus.err), 32'd1);
        read_bits("oor", 8'h00, WL, 1'b1);

        // Address wraps 31 -> 0 during a read burst
        start_frame(1'b0, 5'd31);
        tick();
        read_bits("wrap31", 8'h00, WL, 1'b0);
        read_bits("wrap0", mdl[0], WL, 1'b1);

        // Abort a write to addr 2 after 4 data bits; slave restarts in CMD
        start_frame(1'b1, 5'd2);
        bus.din = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.din = 1'b0;
        strobe_only();
        chk("abort_reg2", 32'(reg_at(2)), 32'(mdl[2]));
        chk("abort_busy", 32'(bus.busy), 32'd1);
        chk("abort_rw", 32'(bus.rw_flag), 32'd0);
        send_cmd_addr(1'b0, 5'd2);
        tick();
        read_bits("abort_rd", mdl[2], WL, 1'b1);
        chk("abort_reg2_post", 32'(reg_at(2)), 32'(mdl[2]));

`ifdef SERIAL_REGFILE_PARITY_EN
        // Parity: bad parity drops the write, good parity commits
        start_frame(1'b1, 5'd5);
        send_word(8'h41, 1'b1);
        chk("par_bad_reg", 32'(reg_at(5)), 32'(mdl[5]));
        chk("par_bad_err", 32'(bus.err), 32'd1);
        start_frame(1'b1, 5'd5);
        send_word(8'h41, 1'b0);
        chk("par_ok_reg", 32'(reg_at(5)), 32'h41);
        chk("par_ok_err", 32'(bus.err), 32'd0);
        mdl[5] = 8'h41;
        send_word(8'h07, 1'b0);
        mdl[6] = 8'h07;
        start_frame(1'b0, 5'd6);
        tick();
        read_bits("par_rd_data", 8'h07, RW, 1'b0);
        chk("par_rd_bit", 32'(bus.dout), 32'd1);
        chk("par_rd_rw", 32'(bus.rw_flag), 32'd1);
        strobe_only();
`endif

        // Reset during DATA bit 3 of a read
        start_frame(1'b0, 5'd1);
        tick();
        read_bits("mid", mdl[1], 3, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mrst_dout", 32'(bus.dout), 32'd0);
        chk("mrst_rw", 32'(bus.rw_flag), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_err", 32'(bus.err), 32'd0);
        for (int k = 0; k < NR; k++) chk("mrst_reg", 32'(reg_at(k)), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_idle_busy", 32'(bus.busy), 32'd0);
        chk("mrst_idle_dout", 32'(bus.dout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
